// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode/funct constants, pc_sel codes, FSM states and scoreboard entry type
package cpu_ctrl_pkg;
  localparam logic [5:0] OP_ARITH = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0e, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2a;
  localparam logic [2:0] PC_SEQ = 3'd0, PC_HOLD = 3'd1, PC_JUMP = 3'd2, PC_BRANCH = 3'd3, PC_JR = 3'd4;
  localparam logic [1:0] ST_RUN = 2'd0, ST_JR_RF = 2'd1, ST_BR_RF = 2'd2, ST_BR_EX = 2'd3;
  typedef struct packed {
    logic       wr;
    logic [4:0] dest;
    logic       load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RF/EX/MEM write shift register (clk, reset, entry in) with rs/rt match outputs
module hazard_scoreboard
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  sb_entry_t  entry,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       load_rs,
  output logic       load_rt,
  output logic       busy_rs
);
  sb_entry_t sb0, sb1, sb2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sb0 <= '0;
      sb1 <= '0;
      sb2 <= '0;
    end else begin
      sb0 <= entry;
      sb1 <= sb0;
      sb2 <= sb1;
    end
  assign load_rs = sb0.wr && sb0.load && sb0.dest == rs;
  assign load_rt = sb0.wr && sb0.load && sb0.dest == rt;
  assign busy_rs = (sb0.wr && sb0.dest == rs) || (sb1.wr && sb1.dest == rs) || (sb2.wr && sb2.dest == rs);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF-stage stall/flush sequencer driving nop_sel, pc_sel, branch_taken and a saturating stall_count
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_IF,
  input  logic             ALUzero,
  output logic             nop_sel,
  output logic [2:0]       pc_sel,
  output logic             branch_taken,
  output logic [CNT_W-1:0] stall_count
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wdst;
  logic [1:0] state, nxt;
  logic is_bne, is_r, is_jr, is_br, is_j, use_rt, load_rs, load_rt, busy_rs, hold, taken, unused_shamt;
  sb_entry_t entry;
  assign op = instr_IF[31:26];
  assign rs = instr_IF[25:21];
  assign rt = instr_IF[20:16];
  assign rd = instr_IF[15:11];
  assign fn = instr_IF[5:0];
  assign unused_shamt = ^instr_IF[10:6];
  assign is_r = op == OP_ARITH;
  assign is_jr = is_r && fn == FN_JR;
  assign is_br = op == OP_BEQ || op == OP_BNE;
  assign is_j = op == OP_J || op == OP_JAL;
  assign use_rt = is_r || is_br || op == OP_SW;
  assign hold = (!is_j && load_rs) || (use_rt && load_rt) || (is_jr && busy_rs);
  assign wdst = (op == OP_LW || op == OP_ADDI || op == OP_XORI) ? rt :
                (is_r && (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT)) ? rd :
                op == OP_JAL ? 5'd31 : 5'd0;
  assign entry = nop_sel ? '0 : {wdst != 5'd0, wdst, op == OP_LW};
  assign taken = is_bne ? !ALUzero : ALUzero;
  assign branch_taken = !reset && state == ST_BR_EX && taken;
  always_comb begin
    nop_sel = reset || state != ST_RUN || hold;
    pc_sel = reset ? PC_HOLD :
             state == ST_JR_RF ? PC_JR :
             state == ST_BR_EX && taken ? PC_BRANCH :
             (state != ST_RUN || hold || is_jr || is_br) ? PC_HOLD :
             is_j ? PC_JUMP : PC_SEQ;
    nxt = state == ST_BR_RF ? ST_BR_EX :
          (state != ST_RUN || hold) ? ST_RUN :
          is_jr ? ST_JR_RF : is_br ? ST_BR_RF : ST_RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_RUN;
      is_bne <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= nxt;
      if (state == ST_RUN && !hold && is_br) is_bne <= op == OP_BNE;
      if (nop_sel && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  hazard_scoreboard u_sb (
    .clk(clk), .reset(reset), .entry(entry), .rs(rs), .rt(rt),
    .load_rs(load_rs), .load_rt(load_rt), .busy_rs(busy_rs)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan plus random instruction stream checked against a queue-based reference model
module tb_pipe_hazard_ctrl;
  logic clk = 0, reset = 1, ALUzero = 0;
  logic [31:0] instr_IF = 0;
  logic nop_sel, branch_taken;
  logic [2:0] pc_sel;
  logic [15:0] stall_count;
  int n_checks = 0, n_errors = 0;
  int hist_dest [3];
  bit hist_load [3];
  int pend [$];
  int cnt;
  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_IF(instr_IF), .ALUzero(ALUzero),
    .nop_sel(nop_sel), .pc_sel(pc_sel), .branch_taken(branch_taken), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] r_ins(int s, int t, int d, int f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
  endfunction
  function automatic logic [31:0] i_ins(int o, int s, int t, int imm);
    return {6'(o), 5'(s), 5'(t), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(int o, int tgt);
    return {6'(o), 26'(tgt)};
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      hist_dest[i] = 0;
      hist_load[i] = 0;
    end
    pend.delete();
    cnt = 0;
  endtask
  task automatic step(input logic [31:0] ins, input bit az);
    int op, rs, rt, rd, fn, s, en, ep, eb, wd;
    bit use_rs, use_rt, lu, busy, is_jr;
    instr_IF = ins;
    ALUzero = az;
    #1;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); fn = int'(ins[5:0]);
    en = 1; ep = 1; eb = 0; wd = 0;
    if (pend.size() != 0) begin
      s = pend.pop_front();
      if (s == 1) ep = 4;
      if (s >= 2) begin
        eb = (s == 2) ? az : !az;
        ep = eb ? 3 : 1;
      end
    end else begin
      use_rs = !(op == 2 || op == 3);
      use_rt = op == 0 || op == 4 || op == 5 || op == 'h2b;
      is_jr = op == 0 && fn == 8;
      lu = hist_load[0] && hist_dest[0] != 0 &&
           ((use_rs && hist_dest[0] == rs) || (use_rt && hist_dest[0] == rt));
      busy = is_jr && rs != 0 && (hist_dest[0] == rs || hist_dest[1] == rs || hist_dest[2] == rs);
      if (!(lu || busy)) begin
        en = 0;
        if (is_jr) begin ep = 1; pend.push_back(1); end
        else if (op == 4 || op == 5) begin ep = 1; pend.push_back(0); pend.push_back(op == 4 ? 2 : 3); end
        else if (op == 2 || op == 3) ep = 2;
        else ep = 0;
        if (op == 'h23 || op == 8 || op == 'h0e) wd = rt;
        else if (op == 0 && (fn == 'h20 || fn == 'h22 || fn == 'h2a)) wd = rd;
        else if (op == 3) wd = 31;
      end
    end
    check("nop_sel", nop_sel, en);
    check("pc_sel", pc_sel, ep);
    check("branch_taken", branch_taken, eb);
    check("stall_count", stall_count, cnt);
    hist_dest[2] = hist_dest[1]; hist_load[2] = hist_load[1];
    hist_dest[1] = hist_dest[0]; hist_load[1] = hist_load[0];
    hist_dest[0] = wd; hist_load[0] = wd != 0 && op == 'h23;
    if (en && cnt < 65535) cnt++;
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    reset = 1;
    #1;
    model_clear();
    for (int i = 0; i < n; i++) begin
      check("rst_nop", nop_sel, 1);
      check("rst_pc", pc_sel, 1);
      check("rst_bt", branch_taken, 0);
      check("rst_cnt", stall_count, 0);
      @(negedge clk);
    end
    reset = 0;
  endtask
  function automatic int rr();
    return ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 6));
  endfunction
  function automatic logic [31:0] rand_ins();
    case ($urandom_range(0, 12))
      0: return r_ins(rr(), rr(), rr(), 'h20);
      1: return r_ins(rr(), rr(), rr(), 'h22);
      2: return r_ins(rr(), rr(), rr(), 'h2a);
      3: return r_ins(rr(), 0, 0, 8);
      4: return i_ins('h23, rr(), rr(), 4);
      5: return i_ins('h2b, rr(), rr(), 4);
      6: return i_ins(8, rr(), rr(), 1);
      7: return i_ins('h0e, rr(), rr(), 3);
      8: return i_ins(4, rr(), rr(), 2);
      9: return i_ins(5, rr(), rr(), 2);
      10: return j_ins(2, 'h40);
      11: return j_ins(3, 'h80);
      default: return r_ins(rr(), rr(), rr(), 'h25);
    endcase
  endfunction
  initial begin
    model_clear();
    @(negedge clk);
    do_reset(3);
    step(r_ins(1, 2, 3, 'h20), 0);
    step(i_ins('h23, 0, 5, 0), 0);
    step(r_ins(5, 1, 6, 'h20), 0);
    step(r_ins(5, 1, 6, 'h20), 0);
    step(i_ins(4, 1, 1, 4), 1);
    step(0, 1);
    step(0, 1);
    step(i_ins(5, 1, 1, 4), 1);
    step(0, 1);
    step(0, 1);
    step(i_ins(8, 0, 4, 8), 0);
    repeat (4) step(r_ins(4, 0, 0, 8), 0);
    step(r_ins(1, 2, 3, 'h20), 0);
    step(r_ins(1, 2, 3, 'h20), 0);
    step(j_ins(3, 'h100), 0);
    step(r_ins(31, 0, 7, 'h20), 0);
    step(i_ins(4, 1, 1, 4), 1);
    do_reset(2);
    step(r_ins(1, 2, 3, 'h20), 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step(rand_ins(), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined CPU. It decodes the instruction at the IF stage and decides each cycle whether that instruction issues or is replaced by a NOP. It also drives the PC-select code for the PC unit. It replaces the unconditional NOP mux with a state machine plus a 3-entry write scoreboard, so bubbles are inserted only on real hazards.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears FSM, scoreboard, counter
- instr_IF  in  32  raw instruction word fetched this cycle
- ALUzero  in  1  ALU zero flag of the instruction in EX
- nop_sel  out  1  1 = replace instr_IF with NOP (32'b0) at the IF/RF boundary
- pc_sel  out  3  next-PC source: 0 SEQ (PC+4), 1 HOLD, 2 JUMP (26-bit target from IF), 3 BRANCH (target from EX), 4 JR (da_RF)
- branch_taken  out  1  pulse in BR_EX when the branch resolves taken
- stall_count  out  CNT_W  number of NOP-injected cycles since reset, saturating

## Operation
- Decode of instr_IF is combinational: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
- Write target of an issued instruction:
  - rt for LW, ADDI, XORI
  - rd for ADD, SUB, SLT
  - 31 for JAL
  - no write otherwise
  - a target of 0 counts as no write
- Source use:
  - rs for every non-J/JAL instruction
  - rt additionally for R-type, BEQ, BNE, SW
- Scoreboard: 3-entry shift register {wr, dest[4:0], load}, with entries sb0 = RF, sb1 = EX, sb2 = MEM. Each cycle, sb0 takes the issued instruction; a NOP or a stalled slot enters as wr=0. sb0 then shifts to sb1, and sb1 to sb2.
- FSM states: RUN, JR_RF, BR_RF, BR_EX.
- RUN, first matching rule wins:
  - Load-use: sb0.load and sb0.dest equals a used source of instr_IF → nop_sel=1, pc_sel=HOLD; stay in RUN.
  - JR (opcode 0, funct 8): if any of sb0..sb2 has wr=1 and dest equals rs → nop_sel=1, pc_sel=HOLD; stay in RUN. Otherwise issue, pc_sel=HOLD, go to JR_RF.
  - BEQ/BNE: issue, pc_sel=HOLD, latch the type, go to BR_RF.
  - J/JAL: issue, pc_sel=JUMP; stay in RUN.
  - Otherwise: issue, pc_sel=SEQ.
- JR_RF: nop_sel=1, pc_sel=JR → RUN.
- BR_RF: nop_sel=1, pc_sel=HOLD → BR_EX.
- BR_EX: nop_sel=1. Taken is ALUzero for BEQ and ~ALUzero for BNE. Taken → pc_sel=BRANCH and branch_taken=1; not taken → pc_sel=HOLD. Either way → RUN.
- stall_count increments on every posedge with nop_sel=1 and holds at all-ones.

## Timing
- Reset values:
  - state RUN
  - scoreboard all wr=0
  - stall_count 0
  - branch_taken 0
  - while reset is high: nop_sel=1, pc_sel=HOLD
- The first instruction issues on the first posedge after reset deasserts.
- nop_sel and pc_sel are Mealy outputs, valid in the same cycle as instr_IF. The PC and the IF/RF register sample them at the next posedge.
- Penalties:
  - branch: 2 bubbles
  - JR: 1 bubble, plus 1–3 data-wait bubbles
  - load-use: 1 bubble
  - J/JAL: 0 bubbles
- Register $0 never causes a hazard.
- A JR or branch arriving during a stall state is not sampled; IF is NOP-replaced in every non-RUN state.
- An asynchronous reset mid-branch or mid-JR returns to RUN immediately, with no PC redirect.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode and funct constants (LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, ARITH, JR, ADD, SUB, SLT)
  - pc_sel encodings PC_SEQ, PC_HOLD, PC_JUMP, PC_BRANCH, PC_JR
  - FSM state encoding
- One sub-module, hazard_scoreboard: the 3-entry shift register, plus match outputs for a given rs/rt pair.

## Test plan
- Reset held for 3 cycles → nop_sel=1, pc_sel=1 throughout. After release, ADD $3,$1,$2 → nop_sel=0, pc_sel=0.
- LW $5,0($0) then ADD $6,$5,$1 → exactly one cycle of nop_sel=1, pc_sel=1; ADD issues the next cycle; stall_count=1.
- BEQ $1,$1 (ALUzero=1 in BR_EX) → two NOP cycles, pc_sel sequence 1,1,3, branch_taken=1. Repeat as BNE → pc_sel 1,1,1, branch_taken=0.
- ADDI $4,$0,8 immediately followed by JR $4 → JR held 3 cycles, then issues; JR_RF gives pc_sel=4 with nop_sel=1.
- JAL then ADD $7,$31,$0 → JAL issues with pc_sel=2 and no bubble; the ADD is not stalled (no load).
- Assert reset during BR_RF → state RUN, no pc_sel=3 ever emitted, stall_count=0.
